mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator side of the data-memory port: accepts one load/store request at a time from the execute stage and issues the word-wide read/write strobes to the data memory.
- Returns load data, sign- or zero-extended, to writeback.
- Supports byte, halfword and word accesses. Data memory is word-only, so sub-word stores are done as read-modify-write (RMW).
- Sits between the core's MEM stage and data_memory.

Parameters:
ADDR_W, 16, width of the memory word address (number of word-index bits driven to the RAM)
RD_LAT, 1, cycles from the first cycle mem_read_signal is high to valid mem_read_data; legal range 1..7

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present; sampled only when req_ready=1
req_ready  output  1  unit idle and able to accept; high only in IDLE
req_write  input  1  1=store, 0=load
req_size  input  2  00=byte, 01=half, 10=word, 11=reserved
req_signed  input  1  loads only: 1=sign-extend, 0=zero-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  output  1  one-cycle pulse: access complete
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  valid with resp_valid: misaligned or reserved size
mem_address  output  ADDR_W  word address = req_addr[ADDR_W+1:2]
mem_read_signal  output  1  read strobe to data memory
mem_write_signal  output  1  write strobe to data memory
mem_write_data  output  32  full-word write data
mem_read_data  input  32  word read data from data memory

Behaviour:
Decided interface:
- One clock; reset is asynchronous and active-high (clk, rst).

Output timing and reset:
- All mem_* outputs, resp_* outputs and state are registered.
- req_ready = (state==IDLE), decoded combinationally from state.
- During rst: state=IDLE; mem_address=0, mem_read_signal=0, mem_write_signal=0, mem_write_data=0; resp_valid=0, resp_rdata=0, resp_err=0; req_ready=1.

States: IDLE, RD, RMW_RD, WR, RESP.
- Request fields are latched at acceptance. The accept cycle is IDLE with req_valid=1 (cycle 0).

Error detection:
- Error if size=11, half with addr[0]=1, or word with addr[1:0]!=0.
- On error: IDLE->RESP with no memory strobe; resp_err=1, resp_rdata=0.

Transitions out of IDLE:
- Load: IDLE->RD. mem_read_signal=1 for exactly RD_LAT cycles (a 3-bit counter tracks them). mem_read_data is captured at the end of the last RD cycle. Then ->RESP. resp_valid is seen in cycle RD_LAT+1.
- Word store: IDLE->WR. mem_write_signal=1 for one cycle with mem_write_data=req_wdata. Then ->RESP. Response in cycle 2.
- Byte/half store: IDLE->RMW_RD (same read sequence as RD) ->WR with merged word ->RESP. Response in cycle RD_LAT+2.
  - Merge: replace byte lane addr[1:0] (byte), or lanes {addr[1],0} and {addr[1],1} (half), keeping the other lanes.

Load extraction (little-endian):
- Byte lane k = mem_read_data[8k+7:8k].
- Half = lanes selected by addr[1].
- Extend to 32 bits per req_signed; a word load ignores req_signed.

Strobes and response:
- mem_address is held constant for the whole access.
- mem_read_signal and mem_write_signal are never high together.
- Both strobes are 0 in IDLE and RESP.
- RESP lasts exactly one cycle, then ->IDLE. Back-to-back requests therefore have a minimum spacing of latency+1.
- req_valid while not ready is ignored, with no side effect.

Reset mid-operation:
- rst asserted in any state aborts the access immediately and asynchronously clears all strobes.
- A partially completed RMW leaves memory unmodified.
- No resp_valid is produced for the aborted request.

Optional Feature:
ACCESS_TRACE_EN
- Defined: on each posedge where resp_valid=1, $display a line with the load/store type, size, byte address in hex, data in decimal (rdata for loads, wdata for stores) and err.
- Not defined: no trace code is compiled; behaviour and timing are identical.

Test Plan:
- RAM word 4 = 0x8000_00F0; load word addr 0x10 -> resp_valid at cycle 2 (RD_LAT=1), resp_rdata=0x8000_00F0, resp_err=0, mem_read_signal high 1 cycle.
- Same word; byte load addr 0x10, signed -> 0xFFFF_FFF0; unsigned -> 0x0000_00F0. Half load addr 0x12, signed -> 0xFFFF_8000.
- RAM word 2 = 0x1122_3344; store byte 0xAA to addr 0x09 -> one read, then one write of 0x1122_AA44, resp at cycle 3, read-back 0x1122_AA44.
- Load word addr 0x06, and separately size=11 -> resp_err=1 at cycle 1, resp_rdata=0, no mem strobe ever asserted.
- Half store 0xBEEF at addr 0x0E with rst pulsed during WR -> mem_write_signal drops immediately, no resp_valid, req_ready=1 after release, next load word 0x0C returns the old value.
- RD_LAT=3 build: load word -> mem_read_signal high 3 cycles, resp_valid at cycle 4; a req_valid held high during the busy cycles is accepted only after RESP.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Bundles for mem_access_unit: the execute-stage request/response channel and
// the word-wide data-memory port.
interface mem_access_unit_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface mem_access_unit_mem_if #(parameter int ADDR_W = 16);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read_signal;
  logic              mem_write_signal;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;

  modport master (
    output mem_address, mem_read_signal, mem_write_signal, mem_write_data,
    input  mem_read_data
  );

  modport slave (
    input  mem_address, mem_read_signal, mem_write_signal, mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-only data memory; sub-word stores use read-modify-write.
// Optional ACCESS_TRACE_EN prints one line per completed access.
module mem_access_unit #(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_access_unit_req_if.slave  req,
  mem_access_unit_mem_if.master mem
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RMW_RD = 3'd2,
    WR     = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

  state_t      state_r;
  logic [1:0]  size_r;
  logic [1:0]  lane_r;
  logic        signed_r;
  logic [31:0] wdata_r;
  logic [2:0]  rd_cnt_r;
  logic        req_err_s;
  logic        unused_s;

  assign req.req_ready = (state_r == IDLE);
  assign unused_s      = ^req.req_addr[31:ADDR_W+2];

  // Picks the addressed byte/half out of a word and extends it to 32 bits.
  function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Overlays right-aligned store data onto the lanes it targets in the old word.
  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] r;
    r = word;
    if (size == 2'b00) begin
      case (lane)
        2'b00:   r[7:0]   = wdata[7:0];
        2'b01:   r[15:8]  = wdata[7:0];
        2'b10:   r[23:16] = wdata[7:0];
        default: r[31:24] = wdata[7:0];
      endcase
    end else if (lane[1]) begin
      r[31:16] = wdata[15:0];
    end else begin
      r[15:0] = wdata[15:0];
    end
    return r;
  endfunction

  // Flags reserved sizes and accesses not aligned to their own size.
  always_comb begin
    req_err_s = 1'b0;
    case (req.req_size)
      2'b00:   req_err_s = 1'b0;
      2'b01:   req_err_s = req.req_addr[0];
      2'b10:   req_err_s = (req.req_addr[1:0] != 2'b00);
      default: req_err_s = 1'b1;
    endcase
  end

  // Access sequencer: owns state, latched request and every registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r              <= IDLE;
      size_r               <= 2'b00;
      lane_r               <= 2'b00;
      signed_r             <= 1'b0;
      wdata_r              <= 32'h0;
      rd_cnt_r             <= 3'd0;
      mem.mem_address      <= '0;
      mem.mem_read_signal  <= 1'b0;
      mem.mem_write_signal <= 1'b0;
      mem.mem_write_data   <= 32'h0;
      req.resp_valid       <= 1'b0;
      req.resp_rdata       <= 32'h0;
      req.resp_err         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req.req_valid) begin
            size_r          <= req.req_size;
            lane_r          <= req.req_addr[1:0];
            signed_r        <= req.req_signed;
            wdata_r         <= req.req_wdata;
            rd_cnt_r        <= 3'd1;
            mem.mem_address <= req.req_addr[ADDR_W+1:2];
            if (req_err_s) begin
              state_r        <= RESP;
              req.resp_valid <= 1'b1;
              req.resp_err   <= 1'b1;
              req.resp_rdata <= 32'h0;
            end else if (!req.req_write) begin
              state_r             <= RD;
              mem.mem_read_signal <= 1'b1;
            end else if (req.req_size == 2'b10) begin
              state_r              <= WR;
              mem.mem_write_signal <= 1'b1;
              mem.mem_write_data   <= req.req_wdata;
            end else begin
              state_r             <= RMW_RD;
              mem.mem_read_signal <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RD, RMW_RD: begin
          // Read data is only valid in the final strobe cycle.
          if (rd_cnt_r == RD_LAT_C) begin
            mem.mem_read_signal <= 1'b0;
            if (state_r == RD) begin
              state_r        <= RESP;
              req.resp_valid <= 1'b1;
              req.resp_err   <= 1'b0;
              req.resp_rdata <= extract_load(mem.mem_read_data, size_r, lane_r, signed_r);
            end else begin
              state_r              <= WR;
              mem.mem_write_signal <= 1'b1;
              mem.mem_write_data   <= merge_store(mem.mem_read_data, wdata_r, size_r, lane_r);
            end
          end else begin
            rd_cnt_r <= rd_cnt_r + 3'd1;
          end
        end
        WR: begin
          mem.mem_write_signal <= 1'b0;
          state_r              <= RESP;
          req.resp_valid       <= 1'b1;
          req.resp_err         <= 1'b0;
          req.resp_rdata       <= 32'h0;
        end
        RESP: begin
          state_r        <= IDLE;
          req.resp_valid <= 1'b0;
          req.resp_err   <= 1'b0;
          req.resp_rdata <= 32'h0;
        end
        default: begin
          state_r              <= IDLE;
          mem.mem_read_signal  <= 1'b0;
          mem.mem_write_signal <= 1'b0;
          req.resp_valid       <= 1'b0;
          req.resp_err         <= 1'b0;
          req.resp_rdata       <= 32'h0;
        end
      endcase
    end
  end

`ifdef ACCESS_TRACE_EN
  logic [31:0] trace_addr_r;
  logic        trace_write_r;
  logic [1:0]  trace_size_r;

  // Keeps the accepted request's descriptor for the trace line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trace_addr_r  <= 32'h0;
      trace_write_r <= 1'b0;
      trace_size_r  <= 2'b00;
    end else if ((state_r == IDLE) && req.req_valid) begin
      trace_addr_r  <= req.req_addr;
      trace_write_r <= req.req_write;
      trace_size_r  <= req.req_size;
    end else begin
      trace_addr_r  <= trace_addr_r;
      trace_write_r <= trace_write_r;
      trace_size_r  <= trace_size_r;
    end
  end

  // Emits one line per completed access.
  always @(posedge clk) begin
    if (req.resp_valid) begin
      $display("mau %s size=%0d addr=0x%08h data=%0d err=%0b",
               trace_write_r ? "store" : "load", trace_size_r, trace_addr_r,
               trace_write_r ? wdata_r : req.resp_rdata, req.resp_err);
    end
  end
`else
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit: RD_LAT=1 instance with a RAM
// model, plus an RD_LAT=3 instance for read latency and busy-time request holding.
module tb_mem_access_unit;
  localparam int ADDR_W = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_unit_req_if                      a_req ();
  mem_access_unit_mem_if #(.ADDR_W(ADDR_W))   a_mem ();
  mem_access_unit_req_if                      b_req ();
  mem_access_unit_mem_if #(.ADDR_W(ADDR_W))   b_mem ();

  mem_access_unit #(.ADDR_W(ADDR_W), .RD_LAT(1)) dut_a (.clk(clk), .rst(rst), .req(a_req), .mem(a_mem));
  mem_access_unit #(.ADDR_W(ADDR_W), .RD_LAT(3)) dut_b (.clk(clk), .rst(rst), .req(b_req), .mem(b_mem));

  // RAM for instance A; data is driven only in the cycle it is valid.
  logic [31:0] ram [0:63];
  logic [2:0]  a_age = 3'd0;
  always_ff @(posedge clk) begin
    if (a_mem.mem_write_signal) ram[a_mem.mem_address[5:0]] <= a_mem.mem_write_data;
    a_age <= a_mem.mem_read_signal ? a_age + 3'd1 : 3'd0;
  end
  assign a_mem.mem_read_data = (a_mem.mem_read_signal && a_age == 3'd0) ?
                               ram[a_mem.mem_address[5:0]] : 32'hDEAD_BEEF;

  // Instance B memory: a fixed word valid in the third read cycle.
  logic [2:0] b_age = 3'd0;
  int         b_wr_cnt = 0;
  always_ff @(posedge clk) begin
    b_age <= b_mem.mem_read_signal ? b_age + 3'd1 : 3'd0;
    if (b_mem.mem_write_signal) b_wr_cnt <= b_wr_cnt + 1;
  end
  assign b_mem.mem_read_data = (b_mem.mem_read_signal && b_age == 3'd2) ? 32'h1234_5678 : 32'hDEAD_BEEF;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t vecs [23];

  function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic sg,
                              input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] er,
                              input logic ee, input int lat, input int nrd, input int nwr);
    vec_t v;
    v.wr = wr; v.size = sz; v.sgn = sg; v.addr = ad; v.wdata = wd;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat; v.exp_rd = nrd; v.exp_wr = nwr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          lat;
    int          nrd;
    int          nwr;
    bit          got;
    bit          addr_bad;
    bit          clash;
    logic [31:0] rdata;
    logic        err;
    lat = 0; nrd = 0; nwr = 0; got = 1'b0; addr_bad = 1'b0; clash = 1'b0;
    rdata = 32'h0; err = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d.ready", idx), 32'(a_req.req_ready), 32'h1);
    a_req.req_write = v.wr; a_req.req_size = v.size; a_req.req_signed = v.sgn;
    a_req.req_addr = v.addr; a_req.req_wdata = v.wdata; a_req.req_valid = 1'b1;
    @(posedge clk);
    #1 a_req.req_valid = 1'b0;
    for (int c = 1; c <= 12 && !got; c++) begin
      @(negedge clk);
      if (a_mem.mem_read_signal) nrd++;
      if (a_mem.mem_write_signal) nwr++;
      if ((a_mem.mem_read_signal || a_mem.mem_write_signal) &&
          a_mem.mem_address != v.addr[ADDR_W+1:2]) addr_bad = 1'b1;
      if (a_mem.mem_read_signal && a_mem.mem_write_signal) clash = 1'b1;
      if (a_req.resp_valid) begin
        got = 1'b1; lat = c; rdata = a_req.resp_rdata; err = a_req.resp_err;
        if (a_mem.mem_read_signal || a_mem.mem_write_signal) clash = 1'b1;
      end
    end
    check($sformatf("v%0d.lat", idx), 32'(lat), 32'(v.exp_lat));
    check($sformatf("v%0d.rdata", idx), rdata, v.exp_rdata);
    check($sformatf("v%0d.err", idx), 32'(err), 32'(v.exp_err));
    check($sformatf("v%0d.reads", idx), 32'(nrd), 32'(v.exp_rd));
    check($sformatf("v%0d.writes", idx), 32'(nwr), 32'(v.exp_wr));
    check($sformatf("v%0d.addr_or_strobe_bad", idx), 32'({addr_bad, clash}), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] rd_mask;
    logic [10:0] rs_mask;
    logic [10:0] rdy_mask;
    logic [31:0] b_rdata4;
    logic [31:0] b_rdata9;
    bit          saw_resp;

    rst = 1'b1;
    a_req.req_valid = 1'b0; a_req.req_write = 1'b0; a_req.req_size = 2'b00;
    a_req.req_signed = 1'b0; a_req.req_addr = 32'h0; a_req.req_wdata = 32'h0;
    b_req.req_valid = 1'b0; b_req.req_write = 1'b0; b_req.req_size = 2'b00;
    b_req.req_signed = 1'b0; b_req.req_addr = 32'h0; b_req.req_wdata = 32'h0;

    //            wr    size   sgn   addr          wdata         exp_rdata     err   lat rd wr
    vecs[0]  = mk(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h8000_00F0, 32'h0000_0000, 1'b0, 2, 0, 1);
    vecs[1]  = mk(1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'h1122_3344, 32'h0000_0000, 1'b0, 2, 0, 1);
    vecs[2]  = mk(1'b1, 2'b10, 1'b0, 32'h0000_000C, 32'hCAFE_0123, 32'h0000_0000, 1'b0, 2, 0, 1);
    vecs[3]  = mk(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h8000_00F0, 1'b0, 2, 1, 0);
    vecs[4]  = mk(1'b0, 2'b00, 1'b1, 32'h0000_0010, 32'h0000_0000, 32'hFFFF_FFF0, 1'b0, 2, 1, 0);
    vecs[5]  = mk(1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h0000_00F0, 1'b0, 2, 1, 0);
    vecs[6]  = mk(1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0000_0000, 32'hFFFF_8000, 1'b0, 2, 1, 0);
    vecs[7]  = mk(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0000_0000, 32'h0000_8000, 1'b0, 2, 1, 0);
    vecs[8]  = mk(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0000_0000, 32'hFFFF_FF80, 1'b0, 2, 1, 0);
    vecs[9]  = mk(1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'h0000_0000, 32'h0000_0000, 1'b0, 2, 1, 0);
    vecs[10] = mk(1'b1, 2'b00, 1'b0, 32'h0000_0009, 32'h1234_56AA, 32'h0000_0000, 1'b0, 3, 1, 1);
    vecs[11] = mk(1'b0, 2'b10, 1'b1, 32'h0000_0008, 32'h0000_0000, 32'h1122_AA44, 1'b0, 2, 1, 0);
    vecs[12] = mk(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0000_0000, 32'h0000_0000, 1'b1, 1, 0, 0);
    vecs[13] = mk(1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 1'b1, 1, 0, 0);
    vecs[14] = mk(1'b1, 2'b01, 1'b0, 32'h0000_0011, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1, 0, 0);
    vecs[15] = mk(1'b1, 2'b10, 1'b0, 32'h0000_000A, 32'h5555_5555, 32'h0000_0000, 1'b1, 1, 0, 0);
    vecs[16] = mk(1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'hFFFF_5A5A, 32'h0000_0000, 1'b0, 3, 1, 1);
    vecs[17] = mk(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h5A5A_00F0, 1'b0, 2, 1, 0);
    vecs[18] = mk(1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0000_0000, 32'h0000_00F0, 1'b0, 2, 1, 0);
    vecs[19] = mk(1'b0, 2'b00, 1'b1, 32'h0000_0012, 32'h0000_0000, 32'h0000_005A, 1'b0, 2, 1, 0);
    vecs[20] = mk(1'b0, 2'b01, 1'b1, 32'h0000_0008, 32'h0000_0000, 32'hFFFF_AA44, 1'b0, 2, 1, 0);
    vecs[21] = mk(1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_00C3, 32'h0000_0000, 1'b0, 3, 1, 1);
    vecs[22] = mk(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hC35A_00F0, 1'b0, 2, 1, 0);

    // Reset values while rst is held.
    #12;
    check("rst.ready", 32'(a_req.req_ready), 32'h1);
    check("rst.strobes", 32'({a_mem.mem_read_signal, a_mem.mem_write_signal}), 32'h0);
    check("rst.mem_address", 32'(a_mem.mem_address), 32'h0);
    check("rst.mem_write_data", a_mem.mem_write_data, 32'h0);
    check("rst.resp", 32'({a_req.resp_valid, a_req.resp_err}), 32'h0);
    check("rst.resp_rdata", a_req.resp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 23; i++) run_vec(i, vecs[i]);

    // Half store to word 3 aborted by reset during the write cycle.
    @(negedge clk);
    a_req.req_write = 1'b1; a_req.req_size = 2'b01; a_req.req_signed = 1'b0;
    a_req.req_addr = 32'h0000_000E; a_req.req_wdata = 32'h0000_BEEF; a_req.req_valid = 1'b1;
    @(posedge clk);
    #1 a_req.req_valid = 1'b0;
    @(negedge clk);
    check("abort.rmw_read", 32'({a_mem.mem_read_signal, a_mem.mem_write_signal}), 32'h2);
    @(negedge clk);
    check("abort.wr_cycle", 32'({a_mem.mem_read_signal, a_mem.mem_write_signal}), 32'h1);
    check("abort.merged", a_mem.mem_write_data, 32'hBEEF_0123);
    #1 rst = 1'b1;
    #1;
    check("abort.strobes_drop", 32'({a_mem.mem_read_signal, a_mem.mem_write_signal}), 32'h0);
    check("abort.ready", 32'(a_req.req_ready), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    saw_resp = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (a_req.resp_valid) saw_resp = 1'b1;
    end
    check("abort.no_resp", 32'(saw_resp), 32'h0);
    check("abort.ready_after", 32'(a_req.req_ready), 32'h1);
    run_vec(100, mk(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0, 32'hCAFE_0123, 1'b0, 2, 1, 0));

    // RD_LAT=3 instance: request held high through the busy window.
    rd_mask = '0; rs_mask = '0; rdy_mask = '0; b_rdata4 = 32'h0; b_rdata9 = 32'h0;
    @(negedge clk);
    b_req.req_write = 1'b0; b_req.req_size = 2'b10; b_req.req_signed = 1'b0;
    b_req.req_addr = 32'h0000_0040; b_req.req_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      rd_mask[c]  = b_mem.mem_read_signal;
      rs_mask[c]  = b_req.resp_valid;
      rdy_mask[c] = b_req.req_ready;
      if (c == 4) b_rdata4 = b_req.resp_rdata;
      if (c == 9) b_rdata9 = b_req.resp_rdata;
    end
    b_req.req_valid = 1'b0;
    check("lat3.read_pattern", 32'(rd_mask), 32'(11'b001_1100_1110));
    check("lat3.resp_pattern", 32'(rs_mask), 32'(11'b010_0001_0000));
    check("lat3.ready_pattern", 32'(rdy_mask), 32'(11'b100_0010_0000));
    check("lat3.rdata_first", b_rdata4, 32'h1234_5678);
    check("lat3.rdata_second", b_rdata9, 32'h1234_5678);
    check("lat3.no_writes", 32'(b_wr_cnt), 32'h0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
